// File: rtl/rr_arb4_pkg.sv
// rr_arb4_pkg: shared state encodings, sizes and rotation mask helper for rr_arb4
package rr_arb4_pkg;
   localparam int NUM_REQ = 4;
   localparam int IDX_W = 2;
   typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;
   function automatic logic [NUM_REQ-1:0] below_mask(input logic [IDX_W-1:0] idx);
      return (NUM_REQ'(1) << idx) - NUM_REQ'(1);
   endfunction
endpackage

// File: rtl/rr_arb4_enc.sv
// rr_arb4_enc: fixed-priority 4-bit encoder, highest set index wins
module rr_arb4_enc
   import rr_arb4_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   output logic               valid,
   output logic [IDX_W-1:0]   idx
);
   assign valid = |req;
   assign idx = req[3] ? 2'd3 : req[2] ? 2'd2 : req[1] ? 2'd1 : 2'd0;
endmodule

// File: rtl/rr_arb4.sv
// rr_arb4: four-requester round-robin arbiter with grant hold, release handshake and hold timeout
module rr_arb4
   import rr_arb4_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               done,
   output logic [NUM_REQ-1:0] gnt,
   output logic               gnt_valid,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               timeout,
   output logic               busy
);
   state_t state;
   logic [IDX_W-1:0] last;
   logic [CNT_W-1:0] cnt;
   logic [NUM_REQ-1:0] mask;
   logic [NUM_REQ-1:0] enc_in;
   logic enc_valid;
   logic [IDX_W-1:0] enc_idx;
   logic abort;
   logic hit;
   logic rel;
   // requesters below the last winner go first; otherwise fall back to the full vector
   assign mask = req & below_mask(last);
   assign enc_in = |mask ? mask : req;
   rr_arb4_enc u_enc (.req(enc_in), .valid(enc_valid), .idx(enc_idx));
   assign abort = ~req[gnt_idx];
   assign hit = (MAX_HOLD != 0) && (cnt == CNT_W'(MAX_HOLD));
   assign rel = done | abort | hit;
   assign busy = state == ST_BUSY;
   assign gnt_valid = busy;
   // grant FSM: IDLE picks a winner, BUSY holds it until done, abort or hold limit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         gnt <= '0;
         gnt_idx <= '0;
         last <= '0;
         cnt <= '0;
         timeout <= 1'b0;
      end else if (state == ST_IDLE) begin
         timeout <= 1'b0;
         if (enc_valid) begin
            state <= ST_BUSY;
            gnt <= NUM_REQ'(1) << enc_idx;
            gnt_idx <= enc_idx;
            last <= enc_idx;
            cnt <= CNT_W'(1);
         end
      end else if (rel) begin
         state <= ST_IDLE;
         gnt <= '0;
         cnt <= '0;
         timeout <= hit & ~done & ~abort;
      end else begin
         cnt <= (cnt != '1) ? cnt + 1'b1 : cnt;
      end
   end
endmodule

// File: doc/rr_arb4.md
Name: rr_arb4

Overview:
- Four-requester round-robin arbiter with grant hold, release handshake and hold timeout.
- Shares one downstream resource among requesters req[3:0].
- Built around the team's fixed-priority 4-bit encoder (highest index wins), plus a rotating mask and a small FSM.
- Sits between requesting masters and the shared resource's select/enable logic.

Parameters:
- MAX_HOLD, 16: max cycles a grant may be held in BUSY before forced release. 0 disables the timeout.
- CNT_W, 5: hold-counter width. Requires MAX_HOLD < 2**CNT_W.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- req  in  4  request per requester; level, held until served
- done  in  1  granted requester finished; sampled only in BUSY
- gnt  out  4  one-hot grant, registered
- gnt_valid  out  1  high while any grant is held (equals |gnt)
- gnt_idx  out  2  index of current/last grant, registered
- timeout  out  1  one-cycle pulse on forced release
- busy  out  1  FSM in BUSY

Behaviour:
- Reset (async, while rst=1): gnt=0, gnt_valid=0, gnt_idx=0, timeout=0, busy=0, state=IDLE, hold counter=0, last=0.
- State IDLE:
  - Compute mask = req bits with index < last.
  - If mask is non-zero, encode mask; otherwise encode req.
  - If the encoder reports valid: next edge enters BUSY, gnt=onehot(idx), gnt_idx=idx, last=idx, counter=1.
  - If no valid request: stay in IDLE, outputs 0.
  - Latency: request sampled at edge t, gnt high after edge t.
  - Priority descends from last-1 and wraps to 3. After a grant to 3, the order is 2,1,0,3. After reset, the highest active index wins first.
- State BUSY: gnt held constant. Release to IDLE on the next edge when any of these hold:
  - (a) done=1
  - (b) req[gnt_idx]=0 (abort)
  - (c) MAX_HOLD!=0 and counter==MAX_HOLD, with no done and no abort
- On release: gnt=0, gnt_valid=0, busy=0, counter=0; gnt_idx keeps its value.
  - Case (c) only: timeout=1 for exactly the release cycle.
- Otherwise in BUSY: counter increments, saturating at 2**CNT_W-1.
- Mandatory turnaround: at least one IDLE cycle with gnt=0 between any two grants, including a re-grant to the same requester.
- Simultaneous events:
  - done and counter==MAX_HOLD in the same cycle: normal release, timeout=0.
  - done with req[gnt_idx]=0: normal release.
- Ignored inputs: done in IDLE; changes on non-granted req bits during BUSY (no preemption).
- Reset mid-BUSY: gnt drops asynchronously, rotation restarts from last=0.
- Invariants: gnt is always one-hot or zero. gnt_valid==busy==|gnt. timeout is never high two consecutive cycles.

Decomposition:
- Shared package/include holds:
  - state encodings ST_IDLE=1'b0, ST_BUSY=1'b1
  - NUM_REQ=4
  - IDX_W=2
- Sub-module: the existing fixed-priority 4-bit encoder (req[3:0] -> valid, index[1:0]).
  - Instantiated once on the muxed (masked or full) vector.
  - Mask generation, FSM, counter and output registers live in rr_arb4.

Test Plan:
- Reset/first grant: rst pulse, then req=4'b0101 → one cycle later gnt=4'b0100, gnt_idx=2, busy=1; timeout=0 throughout.
- Rotation: req=4'b1111 held, done pulsed 1 cycle after each grant → grant order 3,2,1,0,3, with one gnt=0 cycle between grants.
- Abort: grant to 1, then req drops to 4'b0000 without done → gnt=0 next cycle, timeout=0, gnt_idx stays 1.
- Timeout: MAX_HOLD=4, req=4'b0010 held, done never → gnt=4'b0010 for 4 cycles, then gnt=0 with timeout=1 for 1 cycle. Re-grant to 1 after 1 IDLE cycle; with req=4'b0011, grant 0 is served before 1.
- Simultaneous done/timeout: MAX_HOLD=4, done asserted on hold cycle 4 → release, timeout stays 0.
- Async reset mid-BUSY: assert rst between edges while gnt=4'b1000 → gnt=0 and busy=0 immediately. After release with req=4'b1001, grant goes to 3.
